board_position_registers: RTL and testbench

- Holds the 9-cell tic-tac-toe board state, one 2-bit code per cell, and is the sole writer of pos1..pos9.
- Accepts player and computer move requests, enforces turn order and cell legality, and publishes registered cell codes.
- Sits directly upstream of the no-space detector and the winner detector, which consume pos1..pos9 combinationally.
- Cell encoding: 2'b00 empty, 2'b01 player (X), 2'b10 computer (O). 2'b11 is never stored.

---
 rtl/board_position_registers.sv | 153 +++++++++++++++
 tb/tb_board_position_registers.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/board_position_registers.sv
// rtl/board_position_registers.sv - tic-tac-toe board state, move legality and turn tracking (optional undo: MOVE_UNDO_EN)
module board_position_registers #(
    parameter bit FIRST_TURN = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       play_en,
    input  logic       pc_en,
    input  logic [3:0] player_pos,
    input  logic [3:0] computer_pos,
    input  logic       game_over,
`ifdef MOVE_UNDO_EN
    input  logic       undo_en,
`endif
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       move_done,
    output logic       illegal_move,
    output logic [1:0] illegal_code,
    output logic       turn,
    output logic [3:0] move_count
);

    localparam logic [1:0] CELL_EMPTY   = 2'b00;
    localparam logic [1:0] CELL_PLAYER  = 2'b01;
    localparam logic [1:0] CELL_PC      = 2'b10;
    localparam logic [1:0] CODE_OCC     = 2'b01;
    localparam logic [1:0] CODE_RANGE   = 2'b10;
    localparam logic [1:0] CODE_TURN    = 2'b11;

    logic [1:0] r_board [0:8];
    logic       r_turn;
    logic [3:0] r_move_count;
    logic       r_move_done;
    logic       r_illegal_move;
    logic [1:0] r_illegal_code;

`ifdef MOVE_UNDO_EN
    logic       r_hist_valid;
    logic [3:0] r_hist_pos;
`endif

    logic       w_req_active;
    logic       w_wrong_turn;
    logic [3:0] w_req_pos;
    logic       w_in_range;
    logic [8:0] w_sel;
    logic       w_occupied;
    logic [1:0] w_mark;

    // Pick the request belonging to the side on move and classify it
    always_comb begin
        w_req_active = r_turn ? pc_en : play_en;
        w_wrong_turn = r_turn ? (play_en & ~pc_en) : (pc_en & ~play_en);
        w_req_pos    = r_turn ? computer_pos : player_pos;
        w_mark       = r_turn ? CELL_PC : CELL_PLAYER;
        w_in_range   = (w_req_pos >= 4'd1) && (w_req_pos <= 4'd9);
        w_sel        = '0;
        w_occupied   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w_sel[i] = (w_req_pos == 4'(i + 1));
            if (w_sel[i] && (r_board[i] != CELL_EMPTY)) begin
                w_occupied = 1'b1;
            end
        end
    end

    // Board, turn, count and status pulses; game_over freezes everything
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                r_board[i] <= CELL_EMPTY;
            end
            r_turn         <= FIRST_TURN;
            r_move_count   <= 4'd0;
            r_move_done    <= 1'b0;
            r_illegal_move <= 1'b0;
            r_illegal_code <= 2'b00;
`ifdef MOVE_UNDO_EN
            r_hist_valid   <= 1'b0;
            r_hist_pos     <= 4'd0;
`endif
        end else begin
            r_move_done    <= 1'b0;
            r_illegal_move <= 1'b0;
            r_illegal_code <= 2'b00;
            if (!game_over) begin
`ifdef MOVE_UNDO_EN
                if (undo_en) begin
                    if (r_hist_valid) begin
                        for (int i = 0; i < 9; i++) begin
                            if (r_hist_pos == 4'(i + 1)) begin
                                r_board[i] <= CELL_EMPTY;
                            end
                        end
                        r_turn       <= ~r_turn;
                        r_move_count <= r_move_count - 4'd1;
                        r_hist_valid <= 1'b0;
                    end
                end else
`endif
                if (w_req_active) begin
                    if (!w_in_range) begin
                        r_illegal_move <= 1'b1;
                        r_illegal_code <= CODE_RANGE;
                    end else if (w_occupied) begin
                        r_illegal_move <= 1'b1;
                        r_illegal_code <= CODE_OCC;
                    end else begin
                        for (int i = 0; i < 9; i++) begin
                            if (w_sel[i]) begin
                                r_board[i] <= w_mark;
                            end
                        end
                        r_turn       <= ~r_turn;
                        r_move_count <= r_move_count + 4'd1;
                        r_move_done  <= 1'b1;
`ifdef MOVE_UNDO_EN
                        r_hist_valid <= 1'b1;
                        r_hist_pos   <= w_req_pos;
`endif
                    end
                end else if (w_wrong_turn) begin
                    r_illegal_move <= 1'b1;
                    r_illegal_code <= CODE_TURN;
                end
            end
        end
    end

    assign pos1         = r_board[0];
    assign pos2         = r_board[1];
    assign pos3         = r_board[2];
    assign pos4         = r_board[3];
    assign pos5         = r_board[4];
    assign pos6         = r_board[5];
    assign pos7         = r_board[6];
    assign pos8         = r_board[7];
    assign pos9         = r_board[8];
    assign move_done    = r_move_done;
    assign illegal_move = r_illegal_move;
    assign illegal_code = r_illegal_code;
    assign turn         = r_turn;
    assign move_count   = r_move_count;

endmodule

// File: tb/tb_board_position_registers.sv
// tb/tb_board_position_registers.sv - directed vector bench for board_position_registers
module tb_board_position_registers;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       play_en = 1'b0;
    logic       pc_en = 1'b0;
    logic [3:0] player_pos = 4'd0;
    logic [3:0] computer_pos = 4'd0;
    logic       game_over = 1'b0;
    logic       undo_en = 1'b0;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       move_done;
    logic       illegal_move;
    logic [1:0] illegal_code;
    logic       turn;
    logic [3:0] move_count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;

    board_position_registers #(.FIRST_TURN(1'b0)) dut (
        .clock(clock),
        .reset(reset),
        .play_en(play_en),
        .pc_en(pc_en),
        .player_pos(player_pos),
        .computer_pos(computer_pos),
        .game_over(game_over),
`ifdef MOVE_UNDO_EN
        .undo_en(undo_en),
`endif
        .pos1(pos1), .pos2(pos2), .pos3(pos3),
        .pos4(pos4), .pos5(pos5), .pos6(pos6),
        .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .move_done(move_done),
        .illegal_move(illegal_move),
        .illegal_code(illegal_code),
        .turn(turn),
        .move_count(move_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        pe;
        logic [3:0]  pp;
        logic        ce;
        logic [3:0]  cp;
        logic        go;
        logic        ud;
        logic [17:0] eb;
        logic        emd;
        logic        eil;
        logic [1:0]  ec;
        logic        et;
        logic [3:0]  en;
    } vec_t;

    vec_t tv[$];

    function automatic logic [17:0] c(int n, logic [1:0] v);
        logic [17:0] t;
        t = 18'(v);
        return t << (2 * (n - 1));
    endfunction

    task automatic add(input logic rst, input logic pe, input logic [3:0] pp,
                       input logic ce, input logic [3:0] cp, input logic go,
                       input logic ud, input logic [17:0] eb, input logic emd,
                       input logic eil, input logic [1:0] ec, input logic et,
                       input logic [3:0] en);
        vec_t v;
        v.rst = rst; v.pe = pe; v.pp = pp; v.ce = ce; v.cp = cp; v.go = go; v.ud = ud;
        v.eb = eb; v.emd = emd; v.eil = eil; v.ec = ec; v.et = et; v.en = en;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [17:0] eb, input logic emd,
                         input logic eil, input logic [1:0] ec, input logic et,
                         input logic [3:0] en);
        logic [17:0] gb;
        gb = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
        n_tests++;
        if (gb !== eb || move_done !== emd || illegal_move !== eil ||
            illegal_code !== ec || turn !== et || move_count !== en) begin
            n_fail++;
            $display("FAIL %s: got board=%h done=%b ill=%b code=%b turn=%b cnt=%0d, want board=%h done=%b ill=%b code=%b turn=%b cnt=%0d",
                     name, gb, move_done, illegal_move, illegal_code, turn, move_count,
                     eb, emd, eil, ec, et, en);
        end
    endtask

    task automatic drive(input logic rst, input logic pe, input logic [3:0] pp,
                         input logic ce, input logic [3:0] cp, input logic go,
                         input logic ud);
        @(negedge clock);
        reset = rst; play_en = pe; player_pos = pp; pc_en = ce; computer_pos = cp;
        game_over = go; undo_en = ud;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [17:0] b;
        // Reset state
        add(1, 0, 0, 0, 0, 0, 0, 18'd0, 0, 0, 2'b00, 0, 0);
        // Player takes centre
        b = c(5, X);
        add(0, 1, 5, 0, 0, 0, 0, b, 1, 0, 2'b00, 1, 1);
        // Computer targets occupied centre
        add(0, 0, 0, 1, 5, 0, 0, b, 0, 1, 2'b01, 1, 1);
        b = b | c(1, O);
        add(0, 0, 0, 1, 1, 0, 0, b, 1, 0, 2'b00, 0, 2);
        // Both requests on player's turn: computer request silently dropped
        b = b | c(3, X);
        add(0, 1, 3, 1, 7, 0, 0, b, 1, 0, 2'b00, 1, 3);
        // Player alone on computer's turn
        add(0, 1, 4, 0, 0, 0, 0, b, 0, 1, 2'b11, 1, 3);
        // Idle cycle
        add(0, 0, 0, 0, 0, 0, 0, b, 0, 0, 2'b00, 1, 3);
        // Out of range computer requests
        add(0, 0, 0, 1, 0, 0, 0, b, 0, 1, 2'b10, 1, 3);
        add(0, 0, 0, 1, 10, 0, 0, b, 0, 1, 2'b10, 1, 3);
        add(0, 0, 0, 1, 15, 0, 0, b, 0, 1, 2'b10, 1, 3);
        b = b | c(2, O);
        add(0, 0, 0, 1, 2, 0, 0, b, 1, 0, 2'b00, 0, 4);
        // Out of range player requests
        add(0, 1, 0, 0, 0, 0, 0, b, 0, 1, 2'b10, 0, 4);
        add(0, 1, 10, 0, 0, 0, 0, b, 0, 1, 2'b10, 0, 4);
        // Fill the remaining cells
        b = b | c(4, X);
        add(0, 1, 4, 0, 0, 0, 0, b, 1, 0, 2'b00, 1, 5);
        b = b | c(6, O);
        add(0, 0, 0, 1, 6, 0, 0, b, 1, 0, 2'b00, 0, 6);
        b = b | c(7, X);
        add(0, 1, 7, 0, 0, 0, 0, b, 1, 0, 2'b00, 1, 7);
        b = b | c(8, O);
        add(0, 0, 0, 1, 8, 0, 0, b, 1, 0, 2'b00, 0, 8);
        b = b | c(9, X);
        add(0, 1, 9, 0, 0, 0, 0, b, 1, 0, 2'b00, 1, 9);
        // Full board rejects in-range requests as occupied
        add(0, 0, 0, 1, 3, 0, 0, b, 0, 1, 2'b01, 1, 9);
        add(0, 0, 0, 1, 9, 0, 0, b, 0, 1, 2'b01, 1, 9);
        // game_over freezes: no pulses, even for wrong-turn or bad index
        add(0, 0, 0, 1, 1, 1, 0, b, 0, 0, 2'b00, 1, 9);
        add(0, 1, 2, 0, 0, 1, 0, b, 0, 0, 2'b00, 1, 9);
        add(0, 0, 0, 1, 0, 1, 0, b, 0, 0, 2'b00, 1, 9);
        // Reset overrides a simultaneous request
        add(1, 1, 5, 0, 0, 0, 0, 18'd0, 0, 0, 2'b00, 0, 0);
        b = c(9, X);
        add(0, 1, 9, 0, 0, 0, 0, b, 1, 0, 2'b00, 1, 1);
`ifdef MOVE_UNDO_EN
        add(0, 0, 0, 1, 2, 0, 0, b | c(2, O), 1, 0, 2'b00, 0, 2);
        // Undo wins over a concurrent request
        add(0, 0, 0, 1, 4, 0, 1, b, 0, 0, 2'b00, 1, 1);
        // Second undo has no history to consume
        add(0, 0, 0, 0, 0, 0, 1, b, 0, 0, 2'b00, 1, 1);
        add(0, 0, 0, 1, 4, 0, 0, b | c(4, O), 1, 0, 2'b00, 0, 2);
`endif

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].pe, tv[i].pp, tv[i].ce, tv[i].cp, tv[i].go, tv[i].ud);
            check($sformatf("vec%0d", i), tv[i].eb, tv[i].emd, tv[i].eil, tv[i].ec,
                  tv[i].et, tv[i].en);
        end

        // Hand sequence: reset held over several requesting cycles, then first move lands
        drive(1, 1, 1, 0, 0, 0, 0);
        check("hold_rst0", 18'd0, 0, 0, 2'b00, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 0);
        check("hold_rst1", 18'd0, 0, 0, 2'b00, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("first_move", c(1, X), 1, 0, 2'b00, 1, 1);
        // Pulse lasts a single cycle once the request drops
        drive(0, 0, 0, 0, 0, 0, 0);
        check("pulse_end", c(1, X), 0, 0, 2'b00, 1, 1);
        // Computer request held two cycles: second one is wrong-turn free but occupied? no - turn flips to player
        drive(0, 0, 0, 1, 6, 0, 0);
        check("pc_move", c(1, X) | c(6, O), 1, 0, 2'b00, 0, 2);
        drive(0, 0, 0, 1, 6, 0, 0);
        check("pc_repeat", c(1, X) | c(6, O), 0, 1, 2'b11, 0, 2);

        drive(0, 0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
